snitch_icache_event_counter: RTL and testbench

Performance-counter bank for the instruction cache. It accumulates the per-fetch-port `icache_events_t` strobes into individually addressable counters. Counters are parametrised in port count, width and overflow mode, and are read back through a registered request/response handshake. Sits beside `snitch_icache` and is fed from each L0 cache's event output; read by a CSR/peripheral bridge.

---
 rtl/snitch_icache_event_counter.sv | 144 ++++++++++++++
 tb/tb_snitch_icache_event_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_event_counter.sv
// Instruction-cache event counter bank; reads return one cycle after acceptance.
// Single-entry response register: req_ready_o drops while an unconsumed response is held.
// Optional SNITCH_ICACHE_EVENT_TOTALS_EN adds four per-event aggregate counters after the per-port ones.
module snitch_icache_event_counter #(
    parameter int unsigned NR_FETCH_PORTS = 1,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter bit          SATURATE       = 1'b1,
    localparam int unsigned ADDR_W        = $clog2(NR_FETCH_PORTS*4+4)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // bit p*4+e: port p, event e (0 miss, 1 hit, 2 prefetch, 3 double hit)
    input  logic [NR_FETCH_PORTS*4-1:0] events_i,
    input  logic                        clear_i,
    input  logic                        freeze_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [ADDR_W-1:0]           req_addr_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [CNT_WIDTH-1:0]        rsp_data_o,
    output logic                        rsp_ovf_o,
    output logic                        rsp_err_o
);

`ifdef SNITCH_ICACHE_EVENT_TOTALS_EN
    localparam int unsigned NR_CNT = NR_FETCH_PORTS*4 + 4;
`else
    localparam int unsigned NR_CNT = NR_FETCH_PORTS*4;
`endif
    // five extra bits hold the largest possible increment (16 ports)
    localparam int unsigned SUM_W = CNT_WIDTH + 5;

    logic [CNT_WIDTH-1:0] cnt_q [NR_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NR_CNT];
    logic [NR_CNT-1:0]    ovf_q, ovf_d;
    logic [4:0]           inc_amt [NR_CNT];

    logic                 rsp_valid_q, rsp_valid_d;
    logic [CNT_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_ovf_q, rsp_ovf_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [CNT_WIDTH-1:0] rd_data;
    logic                 rd_ovf;
    logic                 rd_err;
    logic                 req_accept;

    always_comb begin
        for (int i = 0; i < NR_FETCH_PORTS*4; i++) begin
            inc_amt[i] = {4'b0, events_i[i]};
        end
`ifdef SNITCH_ICACHE_EVENT_TOTALS_EN
        for (int e = 0; e < 4; e++) begin
            inc_amt[NR_FETCH_PORTS*4+e] = 5'd0;
            for (int p = 0; p < NR_FETCH_PORTS; p++) begin
                inc_amt[NR_FETCH_PORTS*4+e] = inc_amt[NR_FETCH_PORTS*4+e] + {4'b0, events_i[p*4+e]};
            end
        end
`endif
    end

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum   = '0;
        ovf_d = ovf_q;
        for (int i = 0; i < NR_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            sum      = {5'b0, cnt_q[i]} + {{CNT_WIDTH{1'b0}}, inc_amt[i]};
            if (clear_i) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (!freeze_i) begin
                if (|sum[SUM_W-1:CNT_WIDTH]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = SATURATE ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
                end else begin
                    cnt_d[i] = sum[CNT_WIDTH-1:0];
                end
            end
        end
    end

    // Reads sample the registered counters, i.e. the value before this cycle's update
    always_comb begin
        rd_data = '0;
        rd_ovf  = 1'b0;
        rd_err  = 1'b1;
        for (int i = 0; i < NR_CNT; i++) begin
            if (req_addr_i == ADDR_W'(i)) begin
                rd_data = cnt_q[i];
                rd_ovf  = ovf_q[i];
                rd_err  = 1'b0;
            end
        end
    end

    assign req_ready_o = !rsp_valid_q | rsp_ready_i;
    assign req_accept  = req_valid_i & req_ready_o;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_err_d   = rsp_err_q;
        if (req_accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data;
            rsp_ovf_d   = rd_ovf;
            rsp_err_d   = rd_err;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NR_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_ovf_o   = rsp_ovf_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_snitch_icache_event_counter.sv
// Directed bench: two 4-port 8-bit instances (saturating and wrapping) share all stimulus.
// Totals-dependent expectations follow SNITCH_ICACHE_EVENT_TOTALS_EN.
module tb_snitch_icache_event_counter;

    localparam int unsigned NP = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned AW = $clog2(NP*4+4);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [15:0]   events_i = '0;
    logic          clear_i = 1'b0;
    logic          freeze_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic          rsp_ready_i = 1'b1;

    logic          req_ready_a, rsp_valid_a, rsp_ovf_a, rsp_err_a;
    logic [W-1:0]  rsp_data_a;
    logic          req_ready_b, rsp_valid_b, rsp_ovf_b, rsp_err_b;
    logic [W-1:0]  rsp_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    snitch_icache_event_counter #(.NR_FETCH_PORTS(NP), .CNT_WIDTH(W), .SATURATE(1'b1)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .events_i(events_i), .clear_i(clear_i), .freeze_i(freeze_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_a), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_a),
        .rsp_ovf_o(rsp_ovf_a), .rsp_err_o(rsp_err_a)
    );

    snitch_icache_event_counter #(.NR_FETCH_PORTS(NP), .CNT_WIDTH(W), .SATURATE(1'b0)) u_wrap (
        .clk_i(clk_i), .rst_i(rst_i), .events_i(events_i), .clear_i(clear_i), .freeze_i(freeze_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_b), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_b),
        .rsp_ovf_o(rsp_ovf_b), .rsp_err_o(rsp_err_b)
    );

    typedef struct {
        logic [15:0]   ev;
        logic          clr;
        logic          frz;
        logic          rd;
        logic [AW-1:0] addr;
        logic [W-1:0]  exp_data;
        logic          exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reads return the value before the same cycle's update
        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd1,  8'd0, 1'b0};
        vecs[1]  = '{16'h0002, 1'b0, 1'b0, 1'b0, 5'd0,  8'd0, 1'b0};
        vecs[2]  = '{16'h0002, 1'b0, 1'b0, 1'b0, 5'd0,  8'd0, 1'b0};
        vecs[3]  = '{16'h0002, 1'b0, 1'b0, 1'b1, 5'd1,  8'd2, 1'b0};
        vecs[4]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd1,  8'd3, 1'b0};
        vecs[5]  = '{16'h8010, 1'b0, 1'b0, 1'b1, 5'd4,  8'd0, 1'b0};
        vecs[6]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd4,  8'd1, 1'b0};
        vecs[7]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd15, 8'd1, 1'b0};
`ifdef SNITCH_ICACHE_EVENT_TOTALS_EN
        vecs[8]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd19, 8'd1, 1'b0};
`else
        vecs[8]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd19, 8'd0, 1'b1};
`endif
        vecs[9]  = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 5'd1,  8'd3, 1'b0};
        vecs[10] = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 5'd1,  8'd3, 1'b0};
        vecs[11] = '{16'h0002, 1'b0, 1'b0, 1'b1, 5'd2,  8'd0, 1'b0};
        vecs[12] = '{16'h0002, 1'b1, 1'b0, 1'b1, 5'd1,  8'd4, 1'b0};
        vecs[13] = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd1,  8'd0, 1'b0};
        vecs[14] = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd4,  8'd0, 1'b0};
        vecs[15] = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd31, 8'd0, 1'b1};

        repeat (3) step();
        check("rst_vld",   rsp_valid_a, 0);
        check("rst_data",  rsp_data_a,  0);
        check("rst_ovf",   rsp_ovf_a,   0);
        check("rst_err",   rsp_err_a,   0);
        check("rst_ready", req_ready_a, 1);
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            events_i    = vecs[i].ev;
            clear_i     = vecs[i].clr;
            freeze_i    = vecs[i].frz;
            req_valid_i = vecs[i].rd;
            req_addr_i  = vecs[i].addr;
            step();
            check($sformatf("vec%0d_vld", i), rsp_valid_a, vecs[i].rd);
            if (vecs[i].rd) begin
                check($sformatf("vec%0d_data", i), rsp_data_a, vecs[i].exp_data);
                check($sformatf("vec%0d_err", i),  rsp_err_a,  vecs[i].exp_err);
                check($sformatf("vec%0d_ovf", i),  rsp_ovf_a,  0);
            end
        end
        events_i = '0; clear_i = 1'b0; freeze_i = 1'b0; req_valid_i = 1'b0;
        step();

        // Basic count and read latency
        events_i = 16'h0002;
        repeat (5) step();
        events_i = '0;
        req_valid_i = 1'b1; req_addr_i = 5'd1;
        check("basic_pre_vld", rsp_valid_a, 0);
        step();
        req_valid_i = 1'b0;
        check("basic_vld",  rsp_valid_a, 1);
        check("basic_data", rsp_data_a,  5);
        check("basic_ovf",  rsp_ovf_a,   0);
        check("basic_err",  rsp_err_a,   0);
        step();
        check("basic_vld_fall", rsp_valid_a, 0);

        // Overflow: 300 misses saturate at 255 or wrap to 44
        events_i = 16'h0001;
        repeat (300) step();
        events_i = '0;
        req_valid_i = 1'b1; req_addr_i = 5'd0;
        step();
        req_valid_i = 1'b0;
        check("sat_data",  rsp_data_a, 255);
        check("sat_ovf",   rsp_ovf_a,  1);
        check("wrap_data", rsp_data_b, 44);
        check("wrap_ovf",  rsp_ovf_b,  1);
        step();

        // Aggregate prefetch counter at address 18
        events_i = 16'h4444;
        repeat (3) step();
        events_i = '0;
        req_valid_i = 1'b1; req_addr_i = 5'd18;
        step();
        req_valid_i = 1'b0;
`ifdef SNITCH_ICACHE_EVENT_TOTALS_EN
        check("tot_data", rsp_data_a, 12);
        check("tot_err",  rsp_err_a,  0);
`else
        check("tot_data", rsp_data_a, 0);
        check("tot_err",  rsp_err_a,  1);
`endif
        step();

        // Backpressure with a queued request behind a held response
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 5'd0;
        step();
        req_addr_i = 5'd1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp%0d_ready", k), req_ready_a, 0);
            check($sformatf("bp%0d_vld", k),   rsp_valid_a, 1);
            check($sformatf("bp%0d_data", k),  rsp_data_a,  255);
            step();
        end
        rsp_ready_i = 1'b1;
        #1;
        check("bp_release_ready", req_ready_a, 1);
        step();
        req_valid_i = 1'b0;
        check("bp_next_vld",  rsp_valid_a, 1);
        check("bp_next_data", rsp_data_a,  5);
        step();
        check("bp_drain_vld", rsp_valid_a, 0);

        // Clear also drops sticky overflow
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 5'd0;
        step();
        req_valid_i = 1'b0;
        check("clr_data", rsp_data_a, 0);
        check("clr_ovf",  rsp_ovf_a,  0);
        check("clr_wrap_ovf", rsp_ovf_b, 0);
        step();

        // Reset mid-read drops the response asynchronously
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 5'd31;
        step();
        req_valid_i = 1'b0;
        check("mid_pre_err", rsp_err_a, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_rst_vld",   rsp_valid_a, 0);
        check("mid_rst_err",   rsp_err_a,   0);
        check("mid_rst_ready", req_ready_a, 1);
        step();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        step();
        check("post_rst_vld", rsp_valid_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
